// File: rtl/disp_source_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_arb_pkg : shared types/constants for the display source arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package disp_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SHOW = 2'd2
   } arb_state_e;

   localparam int          NUM_SRC    = 3;
   localparam int          ALARM_IDX  = 2;
   localparam logic [1:0]  NONE_IDX   = 2'd3;
   localparam logic [15:0] BLANK_WORD = 16'h0000;
   localparam logic [15:0] WORD_MASK  = 16'h7F80;

   // Alarm wins outright; otherwise first valid source after cur in 0->1->0 order.
   // cur of 2 or NONE restarts the rotation at the lowest valid index.
   function automatic logic [1:0] next_src(input logic [NUM_SRC-1:0] valid,
                                           input logic [1:0]         cur);
      logic [1:0] n;
      n = NONE_IDX;
      if (valid[ALARM_IDX]) begin
         n = 2'(ALARM_IDX);
      end else if (cur == 2'd0) begin
         if (valid[1])      n = 2'd1;
         else if (valid[0]) n = 2'd0;
      end else if (cur == 2'd1) begin
         if (valid[0])      n = 2'd0;
         else if (valid[1]) n = 2'd1;
      end else begin
         if (valid[0])      n = 2'd0;
         else if (valid[1]) n = 2'd1;
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/disp_source_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_arb_if : requester / display-driver bundle of the arbiter       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface disp_arb_if;
   import disp_arb_pkg::*;

   logic [NUM_SRC-1:0] src_valid;
   logic [15:0]        src_word0;
   logic [15:0]        src_word1;
   logic [15:0]        src_word2;
   logic [NUM_SRC-1:0] src_ack;
   logic [15:0]        disp_data;
   logic [1:0]         disp_src;
   logic               disp_blank;

   modport master (
      output src_valid, src_word0, src_word1, src_word2,
      input  src_ack, disp_data, disp_src, disp_blank
   );

   modport slave (
      input  src_valid, src_word0, src_word1, src_word2,
      output src_ack, disp_data, disp_src, disp_blank
   );
endinterface
`default_nettype wire

// File: rtl/disp_source_arbiter_ms_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ms_tick_gen : 1 ms strobe from a TICK_DIV-cycle divider (clear/hold) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ms_tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic en,
   output logic tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] r_cnt;

   assign tick = en && (r_cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (en) begin
         if (r_cnt == CW'(TICK_DIV - 1)) r_cnt <= '0;
         else                            r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/disp_source_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_source_arbiter : round-robin/alarm-preempt 7-seg source sharing |
// | Optional macro DISP_FREEZE_EN adds a freeze input.   Rev 1.0         |
// +----------------------------------------------------------------------+
module disp_source_arbiter
   import disp_arb_pkg::*;
#(
   parameter int TICK_DIV = 50000,
   parameter int DWELL_MS = 2000
) (
   input logic       clk,
   input logic       reset_n,
`ifdef DISP_FREEZE_EN
   input logic       freeze,
`endif
   disp_arb_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'(IDLE);
   localparam logic [1:0] S_LOAD = 2'(LOAD);
   localparam logic [1:0] S_SHOW = 2'(SHOW);
   localparam int         DW_W   = $clog2(DWELL_MS + 1);

   logic [1:0]         r_state;
   logic [1:0]         r_sel;
   logic [DW_W-1:0]    r_dwell_cnt;
   logic [15:0]        r_disp_data;
   logic [1:0]         r_disp_src;
   logic               r_disp_blank;
   logic [NUM_SRC-1:0] r_ack;

   logic               w_freeze;
   logic               w_run;
   logic               w_clear;
   logic               w_tick;
   logic               w_expire;
   logic               w_preempt;
   logic [1:0]         w_next;
   logic [15:0]        w_word;

`ifdef DISP_FREEZE_EN
   assign w_freeze = freeze;
`else
   assign w_freeze = 1'b0;
`endif

   assign w_run     = (r_state == S_SHOW) && !w_freeze;
   assign w_clear   = (r_state != S_SHOW);
   assign w_expire  = w_tick && (r_dwell_cnt == DW_W'(DWELL_MS - 1));
   assign w_preempt = bus.src_valid[ALARM_IDX] && (r_sel != 2'(ALARM_IDX));
   assign w_next    = next_src(bus.src_valid, r_sel);

   always_comb begin
      w_word = BLANK_WORD;
      case (r_sel)
         2'd0:    w_word = bus.src_word0;
         2'd1:    w_word = bus.src_word1;
         2'd2:    w_word = bus.src_word2;
         default: w_word = BLANK_WORD;
      endcase
   end

   ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (w_clear),
      .en      (w_run),
      .tick    (w_tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dwell_cnt <= '0;
      end else if (w_clear) begin
         r_dwell_cnt <= '0;
      end else if (w_run && w_tick) begin
         if (w_expire) r_dwell_cnt <= '0;
         else          r_dwell_cnt <= r_dwell_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_sel        <= 2'd0;
         r_disp_data  <= BLANK_WORD;
         r_disp_src   <= NONE_IDX;
         r_disp_blank <= 1'b1;
         r_ack        <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (|bus.src_valid) begin
                  r_sel   <= next_src(bus.src_valid, NONE_IDX);
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_disp_data  <= w_word & WORD_MASK;
               r_disp_src   <= r_sel;
               r_disp_blank <= 1'b0;
               r_ack        <= 3'b001 << r_sel;
               r_state      <= S_SHOW;
            end
            S_SHOW: begin
               // Alarm preemption ignores both dwell and freeze.
               if (w_preempt) begin
                  r_sel   <= 2'(ALARM_IDX);
                  r_state <= S_LOAD;
               end else if (w_expire) begin
                  if (w_next != NONE_IDX) begin
                     r_sel   <= w_next;
                     r_state <= S_LOAD;
                  end else begin
                     r_disp_data  <= BLANK_WORD;
                     r_disp_src   <= NONE_IDX;
                     r_disp_blank <= 1'b1;
                     r_state      <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.disp_data  = r_disp_data;
   assign bus.disp_src   = r_disp_src;
   assign bus.disp_blank = r_disp_blank;
   assign bus.src_ack    = r_ack;
endmodule
`default_nettype wire

// File: tb/tb_disp_source_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_disp_source_arbiter : directed vectors + multi-cycle sequences    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_disp_source_arbiter;
   localparam int TICK_DIV = 10;
   localparam int DWELL_MS = 3;
   localparam int PERIOD   = DWELL_MS * TICK_DIV + 1;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
`ifdef DISP_FREEZE_EN
   logic freeze  = 1'b0;
`endif

   disp_arb_if bus ();

   disp_source_arbiter #(.TICK_DIV(TICK_DIV), .DWELL_MS(DWELL_MS)) dut (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef DISP_FREEZE_EN
      .freeze  (freeze),
`endif
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  valid;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [15:0] w2;
      logic [1:0]  exp_src;
      logic [15:0] exp_data;
      logic [2:0]  exp_ack;
   } vec_t;

   vec_t vecs [8];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      bus.src_valid = 3'b000;
      bus.src_word0 = 16'h0;
      bus.src_word1 = 16'h0;
      bus.src_word2 = 16'h0;
`ifdef DISP_FREEZE_EN
      freeze        = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wait_ack(output int cyc, input int budget);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (bus.src_ack == 3'b000 && cyc < budget);
   endtask

   task automatic chk_show(input string name, input logic [1:0] src,
                           input logic [15:0] data, input logic [2:0] ack);
      chk({name, "_src"},   32'(bus.disp_src),   32'(src));
      chk({name, "_data"},  32'(bus.disp_data),  32'(data));
      chk({name, "_ack"},   32'(bus.src_ack),    32'(ack));
      chk({name, "_blank"}, 32'(bus.disp_blank), 32'(0));
   endtask

   initial begin
      int c;
      int bad;

      vecs[0] = {3'b001, 16'h1980, 16'h0000, 16'h0000, 2'd0, 16'h1980, 3'b001};
      vecs[1] = {3'b010, 16'h0000, 16'h1900, 16'h0000, 2'd1, 16'h1900, 3'b010};
      vecs[2] = {3'b011, 16'h1900, 16'h1480, 16'h0000, 2'd0, 16'h1900, 3'b001};
      vecs[3] = {3'b110, 16'h0000, 16'h1480, 16'h7F80, 2'd2, 16'h7F80, 3'b100};
      vecs[4] = {3'b111, 16'h1900, 16'h1480, 16'h2A00, 2'd2, 16'h2A00, 3'b100};
      vecs[5] = {3'b001, 16'h1FFF, 16'h0000, 16'h0000, 2'd0, 16'h1F80, 3'b001};
      vecs[6] = {3'b100, 16'h0000, 16'h0000, 16'hFFFF, 2'd2, 16'h7F80, 3'b100};
      vecs[7] = {3'b010, 16'h0000, 16'h8001, 16'h0000, 2'd1, 16'h0000, 3'b010};

      // Selection from IDLE, masking, one-cycle latency and single-cycle ack
      for (int i = 0; i < 8; i++) begin
         do_reset();
         chk("rst_data",  32'(bus.disp_data),  32'h0);
         chk("rst_src",   32'(bus.disp_src),   32'd3);
         chk("rst_blank", 32'(bus.disp_blank), 32'd1);
         chk("rst_ack",   32'(bus.src_ack),    32'd0);
         bus.src_valid = vecs[i].valid;
         bus.src_word0 = vecs[i].w0;
         bus.src_word1 = vecs[i].w1;
         bus.src_word2 = vecs[i].w2;
         step(1);
         chk("lat_ack", 32'(bus.src_ack), 32'd0);
         step(1);
         chk_show($sformatf("vec%0d", i), vecs[i].exp_src, vecs[i].exp_data, vecs[i].exp_ack);
         step(1);
         chk("ack_width", 32'(bus.src_ack), 32'd0);
      end

      // Single source reloads every PERIOD cycles; word change hidden until reload
      do_reset();
      bus.src_valid = 3'b001;
      bus.src_word0 = 16'h1980;
      step(2);
      chk_show("s1_first", 2'd0, 16'h1980, 3'b001);
      bus.src_word0 = 16'h2000;
      step(15);
      chk("s1_hold_data", 32'(bus.disp_data), 32'h1980);
      wait_ack(c, 40);
      chk("s1_period", 32'(c), 32'(PERIOD - 15));
      chk_show("s1_reload", 2'd0, 16'h2000, 3'b001);
      wait_ack(c, 40);
      chk("s1_period2", 32'(c), 32'(PERIOD));

      // Two-source rotation, then alarm preemption 10 cycles into a src0 dwell
      do_reset();
      bus.src_valid = 3'b011;
      bus.src_word0 = 16'h1900;
      bus.src_word1 = 16'h1480;
      step(2);
      chk_show("s2_0", 2'd0, 16'h1900, 3'b001);
      for (int j = 1; j <= 4; j++) begin
         wait_ack(c, 40);
         chk("s2_period", 32'(c), 32'(PERIOD));
         if (j % 2 == 1) chk_show("s2_rot1", 2'd1, 16'h1480, 3'b010);
         else            chk_show("s2_rot0", 2'd0, 16'h1900, 3'b001);
      end
      step(10);
      bus.src_valid = 3'b111;
      bus.src_word2 = 16'h7F80;
      step(1);
      chk("s3_load_src", 32'(bus.disp_src), 32'd0);
      step(1);
      chk_show("s3_alarm", 2'd2, 16'h7F80, 3'b100);
      bus.src_valid = 3'b011;
      wait_ack(c, 40);
      chk("s3_period", 32'(c), 32'(PERIOD));
      chk_show("s3_resume", 2'd0, 16'h1900, 3'b001);

      // Valid dropped mid-dwell: word held to expiry, then blank
      do_reset();
      bus.src_valid = 3'b001;
      bus.src_word0 = 16'h1FFF;
      step(2);
      chk_show("s4_mask", 2'd0, 16'h1F80, 3'b001);
      step(5);
      bus.src_valid = 3'b000;
      step(24);
      chk("s4_hold_data",  32'(bus.disp_data),  32'h1F80);
      chk("s4_hold_blank", 32'(bus.disp_blank), 32'd0);
      step(1);
      chk("s4_idle_blank", 32'(bus.disp_blank), 32'd1);
      chk("s4_idle_src",   32'(bus.disp_src),   32'd3);
      chk("s4_idle_data",  32'(bus.disp_data),  32'h0);

      // Asynchronous reset mid-SHOW
      do_reset();
      bus.src_valid = 3'b011;
      bus.src_word0 = 16'h1900;
      step(12);
      #2;
      reset_n = 1'b0;
      #1;
      chk("s5_data",  32'(bus.disp_data),  32'h0);
      chk("s5_src",   32'(bus.disp_src),   32'd3);
      chk("s5_blank", 32'(bus.disp_blank), 32'd1);
      chk("s5_ack",   32'(bus.src_ack),    32'd0);
      step(2);
      chk("s5_held_src", 32'(bus.disp_src), 32'd3);
      @(negedge clk);
      reset_n = 1'b1;

`ifdef DISP_FREEZE_EN
      // Freeze holds the display; alarm still preempts and then freezes
      do_reset();
      bus.src_valid = 3'b010;
      bus.src_word1 = 16'h1480;
      step(2);
      chk_show("s6_first", 2'd1, 16'h1480, 3'b010);
      freeze = 1'b1;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         step(1);
         if (bus.src_ack != 3'b000 || bus.disp_src != 2'd1) bad++;
      end
      chk("s6_frozen", 32'(bad), 32'd0);
      bus.src_valid = 3'b110;
      bus.src_word2 = 16'h7F80;
      step(2);
      chk_show("s6_alarm", 2'd2, 16'h7F80, 3'b100);
      bad = 0;
      for (int k = 0; k < 60; k++) begin
         step(1);
         if (bus.src_ack != 3'b000 || bus.disp_src != 2'd2) bad++;
      end
      chk("s6_alarm_frozen", 32'(bad), 32'd0);
      freeze = 1'b0;
      bus.src_valid = 3'b010;
      wait_ack(c, 40);
      chk("s6_period", 32'(c), 32'(PERIOD));
      chk_show("s6_resume", 2'd1, 16'h1480, 3'b010);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
